// File: rtl/nice_icb_arb_pkg.sv
// Shared types and constants for the NICE ICB master-port arbiter.
package nice_icb_arb_pkg;

  localparam int unsigned ICB_ADDR_W = 32;
  localparam int unsigned ICB_DATA_W = 32;
  localparam int unsigned ICB_SIZE_W = 2;
  localparam int unsigned N_REQ_DEF  = 2;
  localparam int unsigned ID_W       = $clog2(N_REQ_DEF);

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ICB_ADDR_W-1:0] addr;
    logic                  read;
    logic [ICB_DATA_W-1:0] wdata;
    logic [ICB_SIZE_W-1:0] size;
  } icb_cmd_t;

  // Requester-ID width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nice_icb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding ICB commands.
module nice_icb_id_fifo
  import nice_icb_arb_pkg::*;
#(
  parameter int unsigned WIDTH = ID_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head_id,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head_id = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_id;
    end
  end

endmodule

// File: rtl/nice_icb_arb.sv
// Arbitrates N_REQ requesters onto the NICE ICB master port and routes responses back in order.
// Define NICE_ICB_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module nice_icb_arb
  import nice_icb_arb_pkg::*;
#(
  parameter int unsigned N_REQ           = 2,
  parameter int unsigned ADDR_WIDTH      = ICB_ADDR_W,
  parameter int unsigned DATA_WIDTH      = ICB_DATA_W,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_cmd_valid,
  output logic [N_REQ-1:0]            req_cmd_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_cmd_addr,
  input  logic [N_REQ-1:0]            req_cmd_read,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_cmd_wdata,
  input  logic [N_REQ*2-1:0]          req_cmd_size,
  output logic [N_REQ-1:0]            req_rsp_valid,
  input  logic [N_REQ-1:0]            req_rsp_ready,
  output logic [DATA_WIDTH-1:0]       req_rsp_rdata,
  output logic                        req_rsp_err,
  output logic                        nice_icb_cmd_valid,
  input  logic                        nice_icb_cmd_ready,
  output logic [ADDR_WIDTH-1:0]       nice_icb_cmd_addr,
  output logic                        nice_icb_cmd_read,
  output logic [DATA_WIDTH-1:0]       nice_icb_cmd_wdata,
  output logic [1:0]                  nice_icb_cmd_size,
  input  logic                        nice_icb_rsp_valid,
  output logic                        nice_icb_rsp_ready,
  input  logic [DATA_WIDTH-1:0]       nice_icb_rsp_rdata,
  input  logic                        nice_icb_rsp_err,
  output logic                        nice_mem_holdup,
  output logic                        arb_err
);

  localparam int unsigned IDW = id_width(N_REQ);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] hold_id_q, hold_id_d;
  logic           err_q, err_d;
  logic           rst_dly_q, rst_dly_d;
  logic [IDW-1:0] pick_id, gnt_id, head_id;
  logic           found, blk, gnt_valid, cmd_hs, rsp_hs;
  logic           fifo_full, fifo_empty;
  icb_cmd_t       cmd_arr [N_REQ];
  icb_cmd_t       gnt_cmd;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign cmd_arr[g].addr  = ICB_ADDR_W'(req_cmd_addr[g*ADDR_WIDTH +: ADDR_WIDTH]);
    assign cmd_arr[g].read  = req_cmd_read[g];
    assign cmd_arr[g].wdata = ICB_DATA_W'(req_cmd_wdata[g*DATA_WIDTH +: DATA_WIDTH]);
    assign cmd_arr[g].size  = req_cmd_size[g*2 +: 2];
  end

`ifdef NICE_ICB_ARB_PRIO_EN
  always_comb begin
    pick_id = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_cmd_valid[IDW'(i)]) begin
        pick_id = IDW'(i);
        found   = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  int unsigned    rr_idx;

  // First valid requester at or above the pointer, wrapping.
  always_comb begin
    pick_id = rr_ptr_q;
    found   = 1'b0;
    rr_idx  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rr_idx = (32'(rr_ptr_q) + i) % N_REQ;
      if (!found && req_cmd_valid[IDW'(rr_idx)]) begin
        pick_id = IDW'(rr_idx);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (cmd_hs) begin
      rr_ptr_d = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Command grant, HOLD locking and response routing.
  always_comb begin
    state_d   = state_q;
    hold_id_d = hold_id_q;
    err_d     = err_q;
    rst_dly_d = rst;
    blk       = rst | rst_dly_q;

    gnt_id    = (state_q == HOLD) ? hold_id_q : pick_id;
    gnt_valid = req_cmd_valid[gnt_id];
    gnt_cmd   = cmd_arr[gnt_id];

    nice_icb_cmd_valid     = gnt_valid & ~fifo_full & ~blk;
    req_cmd_ready          = '0;
    req_cmd_ready[gnt_id]  = nice_icb_cmd_ready & ~fifo_full & ~blk;
    cmd_hs                 = nice_icb_cmd_valid & nice_icb_cmd_ready;

    case (state_q)
      ARB: begin
        if (nice_icb_cmd_valid && !cmd_hs) begin
          state_d   = HOLD;
          hold_id_d = gnt_id;
        end
      end
      HOLD: begin
        if (cmd_hs || !gnt_valid) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    req_rsp_valid = '0;
    if (nice_icb_rsp_valid && !fifo_empty && !blk) begin
      req_rsp_valid[head_id] = 1'b1;
    end
    // An unexpected response is swallowed so the bus never wedges.
    nice_icb_rsp_ready = ~blk & (fifo_empty | req_rsp_ready[head_id]);
    rsp_hs             = nice_icb_rsp_valid & nice_icb_rsp_ready & ~fifo_empty;
    if (nice_icb_rsp_valid && nice_icb_rsp_ready && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      hold_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_id_q <= hold_id_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    rst_dly_q <= rst_dly_d;
  end

  nice_icb_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_hs),
    .push_id (gnt_id),
    .pop     (rsp_hs),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign nice_icb_cmd_addr  = ADDR_WIDTH'(gnt_cmd.addr);
  assign nice_icb_cmd_read  = gnt_cmd.read;
  assign nice_icb_cmd_wdata = DATA_WIDTH'(gnt_cmd.wdata);
  assign nice_icb_cmd_size  = gnt_cmd.size;
  assign req_rsp_rdata      = nice_icb_rsp_rdata;
  assign req_rsp_err        = nice_icb_rsp_err;
  assign nice_mem_holdup    = (|req_cmd_valid) | ~fifo_empty | (state_q == HOLD);
  assign arb_err            = err_q;

endmodule
